// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a one-entry valid/ready output register and error pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_byte #(
    parameter int CLOCKS_PER_BIT = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       parity_error
);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLOCKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    sync;
    logic          rx_s;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          data_smp, stop_ok, stop_bad, byte_done;

    assign rx_s = sync[1];

`ifdef UART_RX_PARITY_EN
    logic par_smp, par_bit, par_ok;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        data_smp   = 1'b0;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp    = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) state_next = START;
            end
            START: begin
                // mid start bit: a high line here means the edge was a glitch
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_next = '0;
                    data_smp = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == 3'd7) state_next = PARITY;
`else
                    if (bit_idx == 3'd7) state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL_LAST) begin
                    cnt_next   = '0;
                    par_smp    = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                // leaving at mid stop bit so the following start edge is not missed
                if (cnt == FULL_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        stop_ok    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_next = '0;
                if (rx_s) state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign par_ok    = (par_bit == ^shift);
    assign byte_done = stop_ok && par_ok;

    always_ff @(posedge clock) begin
        if (!reset) begin
            par_bit      <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            if (par_smp) par_bit <= rx_s;
            parity_error <= stop_ok && !par_ok;
        end
    end
`else
    assign byte_done    = stop_ok;
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            sync          <= 2'b11;
            bit_idx       <= '0;
            shift         <= '0;
            data          <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            sync          <= {sync[0], uart_rx};
            framing_error <= stop_bad;
            overrun       <= 1'b0;
            if (data_smp) begin
                shift   <= {rx_s, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end else if (state != DATA) begin
                bit_idx <= '0;
            end
            // a byte may load on the same edge the previous one is consumed
            if (byte_done) begin
                if (!valid || ready) begin
                    data  <= shift;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: stimulus queues expected bytes and error pulses,
// a monitor checks handshakes, pulses and output stability.
module tb_uart_rx_byte;
    localparam int CPB = 12;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, framing_error, overrun, parity_error;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] byte_q[$];
    int exp_fe = 0, exp_ovr = 0, exp_par = 0;

    uart_rx_byte #(.CLOCKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset(reset), .uart_rx(uart_rx),
        .data(data), .valid(valid), .ready(ready),
        .framing_error(framing_error), .overrun(overrun), .parity_error(parity_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bit_out(input logic v);
        uart_rx = v;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_out((^b) ^ par_flip);
`else
        if (par_flip) bit_out(1'b1);
`endif
        bit_out(stop);
        bit_out(1'b1);
    endtask

    // monitor: samples 1 time unit after the falling edge, where inputs and outputs are settled
    initial begin
        logic       pv, pr, prst;
        logic [7:0] pd;
        logic [7:0] e;
        pv = 1'b0; pr = 1'b0; prst = 1'b0; pd = '0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                if (prst && pv && !pr) begin
                    chk("hold_valid", {31'd0, valid}, 32'd1);
                    chk("hold_data", {24'd0, data}, {24'd0, pd});
                end
                if (valid && ready) begin
                    if (byte_q.size() == 0) chk("unexpected_byte", {24'd0, data}, 32'hFFFF_FFFF);
                    else begin
                        e = byte_q.pop_front();
                        chk("byte", {24'd0, data}, {24'd0, e});
                    end
                end
                if (framing_error) begin
                    chk("framing_expected", (exp_fe > 0) ? 32'd1 : 32'd0, 32'd1);
                    if (exp_fe > 0) exp_fe--;
                end
                if (overrun) begin
                    chk("overrun_expected", (exp_ovr > 0) ? 32'd1 : 32'd0, 32'd1);
                    if (exp_ovr > 0) exp_ovr--;
                end
                if (parity_error) begin
                    chk("parity_expected", (exp_par > 0) ? 32'd1 : 32'd0, 32'd1);
                    if (exp_par > 0) exp_par--;
                end
            end
            pv = valid; pr = ready; pd = data; prst = reset;
        end
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_data", {24'd0, data}, 32'd0);
        chk("reset_pulses", {29'd0, framing_error, overrun, parity_error}, 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // 1: basic byte
        byte_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("t1_valid_dropped", {31'd0, valid}, 32'd0);

        // 2: short low glitch, then a real frame
        uart_rx = 1'b0;
        repeat (4) @(negedge clock);
        uart_rx = 1'b1;
        repeat (30) @(negedge clock);
        chk("t2_glitch_no_valid", {31'd0, valid}, 32'd0);
        byte_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);

        // 3: framing error, recovery
        exp_fe++;
        send_frame(8'h3C, 1'b0, 1'b0);
        chk("t3_no_valid", {31'd0, valid}, 32'd0);
        byte_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0);

        // 4: overrun with output register held
        ready = 1'b0;
        byte_q.push_back(8'h11);
        exp_ovr++;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        chk("t4_held_valid", {31'd0, valid}, 32'd1);
        chk("t4_held_data", {24'd0, data}, 32'h11);
        ready = 1'b1;
        @(negedge clock);
        chk("t4_valid_drop", {31'd0, valid}, 32'd0);

        // 5: reset pulse during data bit 4 of 0xF0; rest of the line stays high
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(1'b0);
        uart_rx = 1'b1;
        repeat (6) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (5 + CPB * 4) @(negedge clock);
        chk("t5_no_valid", {31'd0, valid}, 32'd0);
        byte_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);

`ifdef UART_RX_PARITY_EN
        // 6: parity good then bad
        byte_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        exp_par++;
        send_frame(8'h07, 1'b1, 1'b1);
        chk("t6_no_valid", {31'd0, valid}, 32'd0);
`endif

        repeat (20) @(negedge clock);
        chk("bytes_left", byte_q.size(), 32'd0);
        chk("framing_left", exp_fe, 32'd0);
        chk("overrun_left", exp_ovr, 32'd0);
        chk("parity_left", exp_par, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
